// File: rtl/slot_mem_sequencer_if.sv
// CPU-side and SDRAM-side signals of the slot memory sequencer.
// master: the sequencer itself; slave: the CPU/mapper/SDRAM environment.
interface slot_mem_sequencer_if;
    logic        cpu_rd;
    logic [7:0]  cpu_dout;
    logic        ram_cs;
    logic [26:0] mem_addr;
    logic        mem_rnw;
    logic [7:0]  cpu_din;
    logic        cpu_wait;
    logic        sdram_req;
    logic [26:0] sdram_addr;
    logic        sdram_we;
    logic [7:0]  sdram_din;
    logic        sdram_ack;
    logic [7:0]  sdram_dout;
    logic        timeout_err;

    modport master (
        input  cpu_rd, cpu_dout, ram_cs, mem_addr, mem_rnw, sdram_ack, sdram_dout,
        output cpu_din, cpu_wait, sdram_req, sdram_addr, sdram_we, sdram_din, timeout_err
    );

    modport slave (
        output cpu_rd, cpu_dout, ram_cs, mem_addr, mem_rnw, sdram_ack, sdram_dout,
        input  cpu_din, cpu_wait, sdram_req, sdram_addr, sdram_we, sdram_din, timeout_err
    );
endinterface

// File: rtl/slot_mem_sequencer.sv
// Turns each mapper RAM access into exactly one SDRAM request; latency 1 cycle to sdram_req.
// Backpressure: cpu_wait stalls the Z80 until ack/timeout. Option macro: SLOT_MEM_POSTED_WRITE_EN.
module slot_mem_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    slot_mem_sequencer_if.master   bus
);

    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state;
    logic       served;
    logic       owner_waits;
    logic [7:0] cnt;

    logic       start;
    logic       posted;
    logic [7:0] cnt_inc;
    logic       cnt_hit;

    assign start = bus.ram_cs & ~served & (~bus.mem_rnw | bus.cpu_rd);

`ifdef SLOT_MEM_POSTED_WRITE_EN
    assign posted = ~bus.mem_rnw;
`else
    assign posted = 1'b0;
`endif

    // Saturating count of completed REQ cycles; hit means this is the last allowed one.
    assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign cnt_hit = (cnt_inc == TIMEOUT_CNT);

    always_comb begin
        bus.cpu_wait = 1'b0;
        if (state == IDLE)
            bus.cpu_wait = start & ~posted;
        else
            bus.cpu_wait = owner_waits | start;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            served          <= 1'b0;
            owner_waits     <= 1'b0;
            cnt             <= 8'd0;
            bus.sdram_req   <= 1'b0;
            bus.sdram_addr  <= 27'h7FFFFFF;
            bus.sdram_we    <= 1'b0;
            bus.sdram_din   <= 8'h00;
            bus.cpu_din     <= 8'hFF;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.timeout_err <= 1'b0;
            if (!bus.ram_cs)
                served <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        served         <= 1'b1;
                        owner_waits    <= ~posted;
                        bus.sdram_addr <= bus.mem_addr;
                        bus.sdram_we   <= ~bus.mem_rnw;
                        bus.sdram_din  <= bus.cpu_dout;
                        bus.sdram_req  <= 1'b1;
                        cnt            <= 8'd0;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    cnt <= cnt_inc;
                    // An ack arriving on the timeout cycle still completes the access.
                    if (bus.sdram_ack) begin
                        bus.sdram_req <= 1'b0;
                        if (!bus.sdram_we)
                            bus.cpu_din <= bus.sdram_dout;
                        state <= IDLE;
                    end else if (cnt_hit) begin
                        bus.sdram_req   <= 1'b0;
                        bus.cpu_din     <= 8'hFF;
                        bus.timeout_err <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
